// File: rtl/fft_frame_assembler_if.sv
// Handshake and frame bus between a serial sample source, the frame
// assembler and a sequential FFT core that takes a whole frame in parallel.
interface fft_frame_assembler_if #(
    parameter int WIDTH   = 32,
    parameter int SAMPLES = 16
);
    logic [WIDTH-1:0]              in_data;
    logic                          in_valid;
    logic                          in_ready;
    logic                          bitrev_en;
    logic [SAMPLES-1:0][WIDTH-1:0] frame_data;
    logic                          frame_valid;
    logic                          frame_ready;
    logic [15:0]                   frame_cnt;

    // Sample producer / frame consumer side
    modport master (
        output in_data, in_valid, bitrev_en, frame_ready,
        input  in_ready, frame_data, frame_valid, frame_cnt
    );

    // Frame assembler side
    modport slave (
        input  in_data, in_valid, bitrev_en, frame_ready,
        output in_ready, frame_data, frame_valid, frame_cnt
    );
endinterface

// File: rtl/fft_frame_assembler.sv
// Collects a serial sample stream into a circular history and, every HOP
// accepted samples once the history is full, snapshots the newest SAMPLES
// samples into a parallel frame (optionally in bit-reversed order) for an FFT.
module fft_frame_assembler #(
    parameter int WIDTH   = 32,
    parameter int SAMPLES = 16,
    parameter int HOP     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    fft_frame_assembler_if.slave  bus
);
    localparam int PTR_W = $clog2(SAMPLES);
    localparam int HOP_W = (HOP > 1) ? $clog2(HOP) : 1;

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                        state_r;
    state_t                        state_nx_s;
    logic [WIDTH-1:0]              hist_r [SAMPLES];
    logic [PTR_W-1:0]              wr_ptr_r;
    logic [HOP_W-1:0]              hop_cnt_r;
    logic [SAMPLES-1:0][WIDTH-1:0] frame_data_r;
    logic [SAMPLES-1:0][WIDTH-1:0] natural_s;
    logic [SAMPLES-1:0][WIDTH-1:0] ordered_s;
    logic                          frame_valid_r;
    logic [15:0]                   frame_cnt_r;
    logic                          trigger_s;
    logic                          in_ready_s;
    logic                          accept_s;
    logic                          snap_s;

    function automatic logic [PTR_W-1:0] bitrev(input logic [PTR_W-1:0] k);
        logic [PTR_W-1:0] r;
        for (int b = 0; b < PTR_W; b++) begin
            r[b] = k[PTR_W-1-b];
        end
        return r;
    endfunction

    // FSM next state, snapshot trigger and input backpressure
    always_comb begin
        state_nx_s = state_r;
        trigger_s  = 1'b0;
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        snap_s     = 1'b0;
        // During FILL the write pointer doubles as the fill counter.
        case (state_r)
            FILL:    trigger_s = (wr_ptr_r == PTR_W'(SAMPLES - 1));
            STREAM:  trigger_s = (hop_cnt_r == HOP_W'(HOP - 1));
            default: trigger_s = 1'b0;
        endcase
        // Stall only when the next sample would overwrite an unconsumed frame.
        if (!rst) begin
            in_ready_s = 1'b0;
        end else if (trigger_s && frame_valid_r && !bus.frame_ready) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = 1'b1;
        end
        accept_s = bus.in_valid && in_ready_s;
        snap_s   = accept_s && trigger_s;
        if (snap_s && (state_r == FILL)) begin
            state_nx_s = STREAM;
        end else begin
            state_nx_s = state_r;
        end
    end

    // Oldest-to-newest window including the sample being accepted this cycle
    always_comb begin
        natural_s = '0;
        for (int i = 0; i < SAMPLES; i++) begin
            if (i == SAMPLES - 1) begin
                natural_s[i] = bus.in_data;
            end else begin
                natural_s[i] = hist_r[PTR_W'(wr_ptr_r + PTR_W'(i + 1))];
            end
        end
    end

    // Output ordering: natural or bit-reversed (DIT input order)
    always_comb begin
        ordered_s = '0;
        for (int k = 0; k < SAMPLES; k++) begin
            if (bus.bitrev_en) begin
                ordered_s[k] = natural_s[bitrev(PTR_W'(k))];
            end else begin
                ordered_s[k] = natural_s[k];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= FILL;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Write pointer and hop counter advance on each accepted sample
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r  <= '0;
            hop_cnt_r <= '0;
        end else if (accept_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (snap_s || (state_r == FILL)) begin
                hop_cnt_r <= '0;
            end else begin
                hop_cnt_r <= hop_cnt_r + HOP_W'(1);
            end
        end
    end

    // Sample history; contents need no reset since FILL rewrites every slot
    always_ff @(posedge clk) begin
        if (accept_s) begin
            hist_r[wr_ptr_r] <= bus.in_data;
        end
    end

    // Frame register, valid flag and frame counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_data_r  <= '0;
            frame_valid_r <= 1'b0;
            frame_cnt_r   <= 16'd0;
        end else if (snap_s) begin
            frame_data_r  <= ordered_s;
            frame_valid_r <= 1'b1;
            frame_cnt_r   <= frame_cnt_r + 16'd1;
        end else if (frame_valid_r && bus.frame_ready) begin
            frame_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.frame_data  = frame_data_r;
    assign bus.frame_valid = frame_valid_r;
    assign bus.frame_cnt   = frame_cnt_r;
endmodule

// File: tb/tb_fft_frame_assembler.sv
// Self-checking bench for fft_frame_assembler: directed scenarios plus a
// randomized phase, all compared against a queue-based reference model.
module tb_fft_frame_assembler;
    localparam int W    = 32;
    localparam int S    = 16;
    localparam int HOP  = 4;
    localparam int LOG2 = 4;
    localparam int FW   = S * W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_frame_assembler_if #(.WIDTH(W), .SAMPLES(S)) bus ();

    fft_frame_assembler #(.WIDTH(W), .SAMPLES(S), .HOP(HOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [W-1:0]          hist[$];
    int                    n_acc    = 0;
    logic                  m_valid  = 1'b0;
    logic [15:0]           m_cnt    = 16'd0;
    logic [S-1:0][W-1:0]   m_frame  = '0;
    logic                  last_acc = 1'b0;

    task automatic check_val(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_snap(input int n);
        return (n == S) || ((n > S) && ((n - S) % HOP == 0));
    endfunction

    function automatic int rev(input int k);
        int r = 0;
        int x = k;
        for (int b = 0; b < LOG2; b++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    // One clock: drive, check in_ready, clock, update model, check outputs
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic fr,
                         input logic br, input logic rs);
        logic exp_rdy;
        logic acc;
        bus.in_valid    = v;
        bus.in_data     = d;
        bus.frame_ready = fr;
        bus.bitrev_en   = br;
        rst             = rs;
        #2;
        exp_rdy = rs && !(is_snap(n_acc + 1) && m_valid && !fr);
        check_val("in_ready", FW'(bus.in_ready), FW'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk);
        #1;
        if (!rs) begin
            hist.delete();
            n_acc   = 0;
            m_valid = 1'b0;
            m_cnt   = 16'd0;
            m_frame = '0;
        end else begin
            if (m_valid && fr) m_valid = 1'b0;
            if (acc) begin
                hist.push_back(d);
                if (hist.size() > S) void'(hist.pop_front());
                n_acc++;
                if (is_snap(n_acc)) begin
                    for (int k = 0; k < S; k++) begin
                        m_frame[k] = hist[br ? rev(k) : k];
                    end
                    m_valid = 1'b1;
                    m_cnt   = m_cnt + 16'd1;
                end
            end
        end
        last_acc = acc;
        check_val("frame_valid", FW'(bus.frame_valid), FW'(m_valid));
        check_val("frame_cnt", FW'(bus.frame_cnt), FW'(m_cnt));
        check_val("frame_data", bus.frame_data, m_frame);
    endtask

    // Offer one sample until accepted, with a bounded number of attempts
    task automatic send(input logic [W-1:0] d, input logic fr, input logic br);
        int tries = 0;
        do begin
            cycle(1'b1, d, fr, br, 1'b1);
            tries++;
        end while (!last_acc && tries < 20);
        if (!last_acc) check_val("send_timeout", FW'(0), FW'(1));
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Basic frame in natural order
        do_reset(2);
        for (int i = 0; i < S; i++) send(W'(100 * i), 1'b1, 1'b0);
        check_val("basic_valid", FW'(bus.frame_valid), FW'(1));
        check_val("basic_cnt", FW'(bus.frame_cnt), FW'(1));
        for (int k = 0; k < S; k++) check_val("basic_k", FW'(bus.frame_data[k]), FW'(100 * k));

        // Bit-reversed frame
        do_reset(1);
        for (int i = 0; i < S; i++) send(W'(100 * i), 1'b1, 1'b1);
        check_val("brev_0", FW'(bus.frame_data[0]), FW'(0));
        check_val("brev_1", FW'(bus.frame_data[1]), FW'(800));
        check_val("brev_2", FW'(bus.frame_data[2]), FW'(400));
        check_val("brev_3", FW'(bus.frame_data[3]), FW'(1200));
        check_val("brev_15", FW'(bus.frame_data[15]), FW'(1500));

        // Overlapped second frame after HOP more samples
        do_reset(1);
        for (int i = 0; i < 20; i++) send(W'(100 * i), 1'b1, 1'b0);
        check_val("hop_cnt", FW'(bus.frame_cnt), FW'(2));
        for (int k = 0; k < S; k++) check_val("hop_k", FW'(bus.frame_data[k]), FW'(400 + 100 * k));

        // Backpressure: stall before the snapshot sample, release with no bubble
        do_reset(1);
        for (int i = 0; i < 19; i++) send(W'(100 * i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, W'(1900), 1'b0, 1'b0, 1'b1);
        check_val("bp_stall", FW'(bus.in_ready), FW'(0));
        check_val("bp_hold", FW'(bus.frame_data[15]), FW'(1500));
        cycle(1'b1, W'(1900), 1'b1, 1'b0, 1'b1);
        check_val("bp_acc", FW'(last_acc), FW'(1));
        check_val("bp_valid", FW'(bus.frame_valid), FW'(1));
        check_val("bp_k0", FW'(bus.frame_data[0]), FW'(400));
        check_val("bp_cnt", FW'(bus.frame_cnt), FW'(2));
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Mid-fill reset discards history
        do_reset(1);
        for (int i = 0; i < 10; i++) send(W'(100 * i), 1'b1, 1'b0);
        cycle(1'b1, W'(5555), 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < S; j++) begin
            send(W'(j < 10 ? 900 - 100 * j : 1100 + 100 * (j - 10)), 1'b1, 1'b0);
            if (j < S - 1) check_val("rst_novalid", FW'(bus.frame_valid), FW'(0));
        end
        check_val("rst_cnt", FW'(bus.frame_cnt), FW'(1));
        for (int k = 0; k < S; k++)
            check_val("rst_k", FW'(bus.frame_data[k]),
                      FW'(k < 10 ? 900 - 100 * k : 1100 + 100 * (k - 10)));

        // Randomized traffic, backpressure, bit-reversal and occasional resets
        for (int c = 0; c < 3000; c++) begin
            cycle($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 1) != 0, $urandom_range(0, 199) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fft_frame_assembler.md
FFT_FRAME_ASSEMBLER -- requirements
Module: fft_frame_assembler

Interface
REQ-001 Parameter WIDTH, default 32, sample width in bits (unsigned, opaque to the block).
REQ-002 Parameter SAMPLES, default 16, frame length; SHALL be a power of two, 4..1024.
REQ-003 Parameter HOP, default 16, new samples between consecutive frames; legal range 1..SAMPLES (HOP<SAMPLES gives overlapped frames).
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 in_data  input  WIDTH  serial sample.
REQ-007 in_valid  input  1  in_data valid this cycle.
REQ-008 in_ready  output  1  block can accept in_data this cycle.
REQ-009 bitrev_en  input  1  1 = emit frame in bit-reversed index order (DIT FFT input order).
REQ-010 frame_data  output  [SAMPLES-1:0][WIDTH-1:0]  parallel frame for the sequential FFT core's sampleInputs.
REQ-011 frame_valid  output  1  frame_data holds an unconsumed frame.
REQ-012 frame_ready  input  1  downstream FFT accepts the frame this cycle.
REQ-013 frame_cnt  output  16  number of frames emitted since reset, modulo 2^16.

Function
REQ-014 A sample SHALL be accepted exactly on a posedge with in_valid=1 and in_ready=1; no other edge changes sample storage.
REQ-015 Storage SHALL be a circular history of the most recent SAMPLES accepted samples (write pointer wraps SAMPLES-1 -> 0).
REQ-016 States: FILL (fewer than SAMPLES samples accepted since reset) and STREAM; FILL->STREAM on the edge accepting the SAMPLES-th sample; no transition back except by reset.
REQ-017 Snapshot trigger: the accepting edge of the SAMPLES-th sample, and thereafter every HOP-th accepted sample (hop counter 0..HOP-1, cleared at each snapshot).
REQ-018 On a snapshot edge, frame_data SHALL load the SAMPLES most recent samples including the one being accepted; natural index 0 = oldest, SAMPLES-1 = newest.
REQ-019 If bitrev_en=1 at the snapshot edge, frame_data[k] SHALL hold natural index bitrev(k) (log2(SAMPLES) bits reversed); bitrev_en is ignored at all other edges.
REQ-020 frame_valid SHALL be 1 from the cycle after a snapshot edge until the edge where frame_valid=1 and frame_ready=1; frame_data SHALL be stable throughout.
REQ-021 Latency: completing sample accepted at edge N -> frame_valid=1 and frame_data valid after edge N (one cycle).
REQ-022 frame_cnt SHALL increment by 1 on every snapshot edge, wrapping 0xFFFF -> 0.
REQ-023 in_ready SHALL be 0 only when the next accepted sample would trigger a snapshot while frame_valid=1 and frame_ready=0; otherwise 1 (outside reset). Combinational from frame_ready is permitted.
REQ-024 Simultaneous consume and snapshot on the same edge: new frame loads, frame_valid stays 1, frame_cnt increments; no bubble.
REQ-025 A frame SHALL never be overwritten or dropped before consumption; samples SHALL never be dropped (backpressure only).
REQ-026 HOP=SAMPLES: non-overlapping frames; HOP=1: snapshot on every accepted sample in STREAM.
REQ-027 frame_ready while frame_valid=0 SHALL have no effect.

Reset
REQ-028 While rst=0 at a posedge: state FILL, write pointer, hop and fill counters 0, frame_valid=0, frame_cnt=0, frame_data all zero.
REQ-029 in_ready SHALL be 0 while rst=0 and 1 in the first cycle after rst returns to 1.
REQ-030 Reset mid-fill or mid-hold SHALL discard all history and any pending frame; the next frame requires SAMPLES fresh samples.

Verification
REQ-031 Defaults, bitrev_en=0, frame_ready=1, feed 0,100,...,1500 back-to-back -> frame_valid one cycle after 16th sample, frame_data[k]=100k, frame_cnt=1.
REQ-032 HOP=4, feed 0,100,...,1900 -> frame 1 = 0..1500, frame 2 (after 20th sample) frame_data[k]=400+100k, frame_cnt=2.
REQ-033 bitrev_en=1, same 16 samples -> frame_data[1]=800, frame_data[2]=400, frame_data[3]=1200, frame_data[15]=1500.
REQ-034 HOP=4, frame_ready=0 after frame 1, keep in_valid=1 -> 3 more samples accepted, in_ready=0 before 4th, frame_data unchanged; frame_ready=1 for one cycle -> in_ready=1 same cycle, 4th sample accepted on that edge, frame 2 valid with no bubble.
REQ-035 Feed 10 samples, assert rst=0 for one edge, feed 900,800,...,0,1100,...,1600 -> no frame before 16th post-reset sample; frame_data equals the post-reset sequence, frame_cnt=1.
